ahblite_slave_mux: RTL and testbench

AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

---
 rtl/ahblite_pkg.sv | 40 ++++
 rtl/ahblite_slave_mux_default_slave.sv | 106 ++++++++++
 rtl/ahblite_slave_mux.sv | 157 +++++++++++++++
 tb/tb_ahblite_slave_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahblite_pkg
//  Description : Shared AHB-Lite encodings, slave-mux port count, default-slave
//                state type and the slave-select priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahblite_pkg;

    localparam int c_NUM_PORTS = 5;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // Keep only the lowest-index set bit; lowest port wins on overlapping selects.
    function automatic logic [c_NUM_PORTS-1:0] lowest_set(input logic [c_NUM_PORTS-1:0] v);
        logic [c_NUM_PORTS-1:0] result;
        result = '0;
        for (int i = c_NUM_PORTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                result    = '0;
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahblite_slave_mux_default_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahblite_default_slave
//  Description : Default slave for the AHB-Lite slave mux. Produces the
//                two-cycle ERROR response for unmapped transfers and, when
//                AHBLITE_SLAVEMUX_TIMEOUT_EN is defined, for slaves that stall
//                for TIMEOUT_CYCLES consecutive data-phase cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hready,
    input  logic i_unmapped_req,
    input  logic i_sel_active,
    input  logic i_slave_ready,
    output logic o_active,
    output logic o_hreadyout,
    output logic o_hresp,
    output logic o_timeout_clr
);

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    ds_state_t r_state;
    logic      r_hreadyout;
    logic      r_hresp;
    logic      w_timeout_fire;

`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
    logic [15:0] r_timeout_cnt;
    logic        w_stalled;

    assign w_stalled      = (r_state == DS_IDLE) && i_sel_active && !i_slave_ready;
    assign w_timeout_fire = w_stalled && (r_timeout_cnt == c_TIMEOUT_LAST);

    // Count consecutive stalled data-phase cycles of the routed slave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_cnt <= '0;
        end else if (w_stalled && !w_timeout_fire) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end else begin
            r_timeout_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout_fire   = 1'b0;
    assign w_unused_timeout = &{1'b0, i_sel_active, i_slave_ready, c_TIMEOUT_LAST};
`endif

    // Default-slave sequencer with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DS_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= c_HRESP_OKAY;
        end else begin
            case (r_state)
                DS_IDLE: begin
                    if (w_timeout_fire || (i_hready && i_unmapped_req)) begin
                        r_state     <= DS_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= c_HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    r_state     <= DS_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= c_HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (i_hready) begin
                        if (i_unmapped_req) begin
                            r_state     <= DS_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= c_HRESP_ERROR;
                        end else begin
                            r_state     <= DS_IDLE;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= c_HRESP_OKAY;
                        end
                    end
                end
                default: begin
                    r_state     <= DS_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= c_HRESP_OKAY;
                end
            endcase
        end
    end

    assign o_active      = (r_state != DS_IDLE);
    assign o_hreadyout   = r_hreadyout;
    assign o_hresp       = r_hresp;
    assign o_timeout_clr = w_timeout_fire;

endmodule
`default_nettype wire

// File: rtl/ahblite_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahblite_slave_mux
//  Description : AHB-Lite five-port slave response multiplexer with a built-in
//                default slave for unmapped or disabled-port transfers.
//                Optional macro AHBLITE_SLAVEMUX_TIMEOUT_EN adds a wait-state
//                watchdog that errors out a slave stalling TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter bit          Port0_en       = 1'b1,
    parameter bit          Port1_en       = 1'b1,
    parameter bit          Port2_en       = 1'b0,
    parameter bit          Port3_en       = 1'b1,
    parameter bit          Port4_en       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    logic [c_NUM_PORTS-1:0] w_hsel_req;
    logic [c_NUM_PORTS-1:0] w_hsel_pri;
    logic [c_NUM_PORTS-1:0] r_sel;
    logic [1:0]             r_htrans;
    logic                   w_unmapped_req;

    logic                   w_ready [c_NUM_PORTS];
    logic                   w_resp  [c_NUM_PORTS];
    logic [31:0]            w_rdata [c_NUM_PORTS];

    logic                   w_slv_ready;
    logic                   w_slv_resp;
    logic [31:0]            w_slv_rdata;

    logic                   w_ds_active;
    logic                   w_ds_hreadyout;
    logic                   w_ds_hresp;
    logic                   w_timeout_clr;

    // A disabled port's select is dropped here so it can never be recorded.
    assign w_hsel_req = {P4_HSEL & Port4_en,
                         P3_HSEL & Port3_en,
                         P2_HSEL & Port2_en,
                         P1_HSEL & Port1_en,
                         P0_HSEL & Port0_en};
    assign w_hsel_pri = lowest_set(w_hsel_req);

    assign w_unmapped_req = (w_hsel_pri == '0) &&
                            ((HTRANS == c_HTRANS_NONSEQ) || (HTRANS == c_HTRANS_SEQ));

    assign w_ready = '{P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT};
    assign w_resp  = '{P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP};
    assign w_rdata = '{P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA};

    // Capture the address phase when the bus advances; a timeout abandons the slave.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sel    <= '0;
            r_htrans <= c_HTRANS_IDLE;
        end else if (w_timeout_clr) begin
            r_sel    <= '0;
            r_htrans <= c_HTRANS_IDLE;
        end else if (HREADY) begin
            r_sel    <= w_hsel_pri;
            r_htrans <= HTRANS;
        end
    end

    // Pick the recorded slave's response (r_sel is one-hot or zero).
    always_comb begin
        w_slv_ready = 1'b0;
        w_slv_resp  = c_HRESP_OKAY;
        w_slv_rdata = '0;
        for (int i = 0; i < c_NUM_PORTS; i++) begin
            if (r_sel[i]) begin
                w_slv_ready = w_ready[i];
                w_slv_resp  = w_resp[i];
                w_slv_rdata = w_rdata[i];
            end
        end
    end

    ahblite_default_slave #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_default_slave (
        .clk            (HCLK),
        .rst_n          (HRESETn),
        .i_hready       (HREADY),
        .i_unmapped_req (w_unmapped_req),
        .i_sel_active   (|r_sel),
        .i_slave_ready  (w_slv_ready),
        .o_active       (w_ds_active),
        .o_hreadyout    (w_ds_hreadyout),
        .o_hresp        (w_ds_hresp),
        .o_timeout_clr  (w_timeout_clr)
    );

    // Return path: default slave while it is sequencing, else the recorded slave.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = c_HRESP_OKAY;
        HRDATA    = '0;
        if (w_ds_active) begin
            HREADYOUT = w_ds_hreadyout;
            HRESP     = w_ds_hresp;
        end else if (|r_sel) begin
            HREADYOUT = w_slv_ready;
            HRESP     = w_slv_resp;
            HRDATA    = w_slv_rdata;
        end else begin
            case (r_htrans)
                c_HTRANS_NONSEQ, c_HTRANS_SEQ: begin
                    HREADYOUT = w_ds_hreadyout;
                    HRESP     = w_ds_hresp;
                end
                c_HTRANS_IDLE, c_HTRANS_BUSY: begin
                    HREADYOUT = 1'b1;
                    HRESP     = c_HRESP_OKAY;
                end
                default: begin
                    HREADYOUT = 1'b1;
                    HRESP     = c_HRESP_OKAY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahblite_slave_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ahblite_slave_mux
//  Description : Self-checking bench for ahblite_slave_mux (default port
//                enables, TIMEOUT_CYCLES = 4). HREADY is looped back from
//                HREADYOUT as in a single-layer AHB-Lite system.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahblite_slave_mux;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D3 = 32'hA5A5_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  hsel;
    logic [4:0]  rdy;
    logic [4:0]  rsp;
    logic [1:0]  htrans;
    logic [31:0] rdata [5];
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign hready = hreadyout;

    ahblite_slave_mux #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK         (clk),
        .HRESETn      (rst_n),
        .HREADY       (hready),
        .HTRANS       (htrans),
        .P0_HSEL      (hsel[0]),
        .P1_HSEL      (hsel[1]),
        .P2_HSEL      (hsel[2]),
        .P3_HSEL      (hsel[3]),
        .P4_HSEL      (hsel[4]),
        .P0_HREADYOUT (rdy[0]),
        .P1_HREADYOUT (rdy[1]),
        .P2_HREADYOUT (rdy[2]),
        .P3_HREADYOUT (rdy[3]),
        .P4_HREADYOUT (rdy[4]),
        .P0_HRESP     (rsp[0]),
        .P1_HRESP     (rsp[1]),
        .P2_HRESP     (rsp[2]),
        .P3_HRESP     (rsp[3]),
        .P4_HRESP     (rsp[4]),
        .P0_HRDATA    (rdata[0]),
        .P1_HRDATA    (rdata[1]),
        .P2_HRDATA    (rdata[2]),
        .P3_HRDATA    (rdata[3]),
        .P4_HRDATA    (rdata[4]),
        .HREADYOUT    (hreadyout),
        .HRESP        (hresp),
        .HRDATA       (hrdata)
    );

    typedef struct packed {
        logic [4:0]  sel;
        logic [1:0]  trans;
        logic [4:0]  rdy;
        logic [4:0]  rsp;
        logic        e_rdy;
        logic        e_rsp;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [19];

    task automatic drive(input logic [4:0] s, input logic [1:0] t,
                         input logic [4:0] r, input logic [4:0] p);
        hsel   = s;
        htrans = t;
        rdy    = r;
        rsp    = p;
    endtask

    task automatic compare(input string nm, input logic er, input logic ep,
                           input logic [31:0] ed);
        n_tests++;
        if (hreadyout !== er || hresp !== ep || hrdata !== ed) begin
            n_fail++;
            $display("FAIL %s: got HREADYOUT=%b HRESP=%b HRDATA=%h, expected %b %b %h",
                     nm, hreadyout, hresp, hrdata, er, ep, ed);
        end
    endtask

    task automatic step_check(input string nm, input logic er, input logic ep,
                              input logic [31:0] ed);
        @(negedge clk);
        compare(nm, er, ep, ed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: address phase presented this cycle, expected outputs of the
        // data phase captured on the previous row.
        vecs[0]  = '{5'b00000, T_IDLE,   5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{5'b00001, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{5'b01001, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b0, D0};
        vecs[3]  = '{5'b01000, T_SEQ,    5'b11111, 5'b00000, 1'b1, 1'b0, D0};
        vecs[4]  = '{5'b00010, T_NONSEQ, 5'b11110, 5'b00001, 1'b1, 1'b0, D3};
        vecs[5]  = '{5'b00100, T_IDLE,   5'b11111, 5'b00000, 1'b1, 1'b0, D1};
        vecs[6]  = '{5'b00100, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{5'b00000, T_IDLE,   5'b11111, 5'b00000, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{5'b00000, T_IDLE,   5'b11111, 5'b00000, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{5'b10000, T_BUSY,   5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{5'b00000, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{5'b00000, T_NONSEQ, 5'b11111, 5'b00000, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{5'b00000, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b1, 32'h0};
        vecs[13] = '{5'b00001, T_NONSEQ, 5'b11111, 5'b00000, 1'b0, 1'b1, 32'h0};
        vecs[14] = '{5'b00001, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b1, 32'h0};
        vecs[15] = '{5'b01000, T_NONSEQ, 5'b11111, 5'b00000, 1'b1, 1'b0, D0};
        vecs[16] = '{5'b00000, T_IDLE,   5'b10111, 5'b01000, 1'b0, 1'b1, D3};
        vecs[17] = '{5'b00000, T_IDLE,   5'b11111, 5'b01000, 1'b1, 1'b1, D3};
        vecs[18] = '{5'b00000, T_IDLE,   5'b11111, 5'b00000, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < 5; i++) rdata[i] = 32'hA5A5_0000 | i;

        // Reset asserted before any clock edge: outputs must already be idle.
        rst_n = 1'b0;
        drive(5'b00010, T_NONSEQ, 5'b11111, 5'b00000);
        #2;
        compare("reset_state", 1'b1, 1'b0, 32'h0);
        #10;
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sel, vecs[i].trans, vecs[i].rdy, vecs[i].rsp);
            step_check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_rsp, vecs[i].e_data);
        end

        // Single read from P1 with zero wait states.
        rdata[1] = 32'hDEAD_BEEF;
        drive(5'b00010, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("p1_addr", 1'b1, 1'b0, 32'h0);
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        step_check("p1_read", 1'b1, 1'b0, 32'hDEAD_BEEF);
        rdata[1] = D1;

        // P3 stalls three cycles while the master holds a P0 address phase.
        drive(5'b01000, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("p3_addr", 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(5'b00001, T_NONSEQ, 5'b10111, 5'b00000);
            step_check($sformatf("p3_stall%0d", k), 1'b0, 1'b0, D3);
        end
        drive(5'b00001, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("p3_release", 1'b1, 1'b0, D3);
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        step_check("p0_after_stall", 1'b1, 1'b0, D0);

        // Asynchronous reset in the middle of the first error cycle.
        drive(5'b00000, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("rst_unmapped_addr", 1'b1, 1'b0, 32'h0);
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        #1;
        compare("rst_in_err1", 1'b0, 1'b1, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        compare("rst_async_idle", 1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(5'b00010, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("rst_after_addr", 1'b1, 1'b0, 32'h0);
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        step_check("rst_after_read", 1'b1, 1'b0, D1);

        // P0 stalls indefinitely.
        drive(5'b00001, T_NONSEQ, 5'b11111, 5'b00000);
        step_check("stall_addr", 1'b1, 1'b0, 32'h0);
`ifdef AHBLITE_SLAVEMUX_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            drive(5'b00000, T_IDLE, 5'b11110, 5'b00000);
            step_check($sformatf("to_wait%0d", k), 1'b0, 1'b0, D0);
        end
        step_check("to_err1", 1'b0, 1'b1, 32'h0);
        step_check("to_err2", 1'b1, 1'b1, 32'h0);
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        step_check("to_after", 1'b1, 1'b0, 32'h0);
`else
        begin
            int bad_cycles;
            bad_cycles = 0;
            for (int k = 0; k < 1000; k++) begin
                drive(5'b00000, T_IDLE, 5'b11110, 5'b00000);
                @(negedge clk);
                if (hreadyout !== 1'b0 || hresp !== 1'b0 || hrdata !== D0) bad_cycles++;
                @(posedge clk);
                #1;
            end
            n_tests++;
            if (bad_cycles != 0) begin
                n_fail++;
                $display("FAIL long_stall: got %0d cycles not stalled-OKAY, expected 0", bad_cycles);
            end
        end
        drive(5'b00000, T_IDLE, 5'b11111, 5'b00000);
        step_check("stall_release", 1'b1, 1'b0, D0);
        step_check("stall_idle", 1'b1, 1'b0, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
